// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// opcode constants and the datapath mux select encodings.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] RES_ALUREG  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALUOUT  = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic op_supported(input logic [6:0] opc);
    return (opc == OP_LOAD)  || (opc == OP_STORE)  || (opc == OP_RTYPE) ||
           (opc == OP_ITYPE) || (opc == OP_BRANCH) || (opc == OP_JAL);
  endfunction

endpackage

// File: rtl/mc_control_immdecode.sv
// Immediate format select, decoded purely from the opcode in every state.
module immdecode
  import mc_control_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V style control FSM. Outputs follow the current state;
// write strobes are additionally gated by rst_n so reset kills them at once.
module mc_control
  import mc_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic       EQ,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q, state_d;
  logic   pc_write, ir_write, mem_write, reg_write, illegal_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUREG;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ResultSrc = RES_ALUOUT;
        ALUSrcB   = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        illegal_op = !op_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_MEMDATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUop   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      // This core's only branch opcode is bne: redirect when operands differ.
      S_BRANCH: begin
        ALUSrcA  = SRCA_RS1;
        ALUop    = ALUOP_CMP;
        pc_write = ~EQ;
      end
      S_JAL: begin
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite  = pc_write   & rst_n;
  assign IRWrite  = ir_write   & rst_n;
  assign MemWrite = mem_write  & rst_n;
  assign RegWrite = reg_write  & rst_n;
  assign illegal  = illegal_op & rst_n;
  assign state    = state_q;

  immdecode u_immdecode (
    .op      (op),
    .imm_src (ImmSrc)
  );

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench: per-instruction cycle sequences built from the opcode's
// step list feed a stimulus queue and an expected-output scoreboard.
module tb_mc_control;
  import mc_control_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic       EQ = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc;
  logic [3:0] state;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .op(op), .EQ(EQ), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .ImmSrc(ImmSrc), .illegal(illegal),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mr;
    logic       eq;
    logic [6:0] op;
  } stim_t;

  stim_t       stim_q[$];
  logic [19:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          driven = 0;
  int          checked = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111};
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  // One expected cycle: inputs to drive plus the full expected output vector.
  task automatic push(input logic [3:0] st, input logic mr, input logic e,
                      input logic [6:0] o, input logic pcw, input logic adr,
                      input logic irw, input logic mw, input logic rw,
                      input logic [1:0] res, input logic [1:0] sa,
                      input logic [1:0] sb, input logic [1:0] aop, input logic ill);
    stim_t s;
    s.mr = mr; s.eq = e; s.op = o;
    stim_q.push_back(s);
    exp_q.push_back({st, pcw, adr, irw, mw, rw, res, sa, sb, aop, imm_of(o), ill});
  endtask

  task automatic gen_instr(input logic [6:0] o, input int fst, input int mst, input logic beq);
    for (int i = 0; i < fst; i++)
      push(S_FETCH, 1'b0, rb(), o, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    push(S_FETCH, 1'b1, rb(), o, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0);
    push(S_DECODE, rb(), rb(), o, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, !legal(o));
    case (o)
      7'b0000011: begin
        push(S_MEMADR, rb(), rb(), o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        for (int i = 0; i < mst; i++)
          push(S_MEMREAD, 1'b0, rb(), o, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        push(S_MEMREAD, 1'b1, rb(), o, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        push(S_MEMWB, rb(), rb(), o, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0);
      end
      7'b0100011: begin
        push(S_MEMADR, rb(), rb(), o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        for (int i = 0; i < mst; i++)
          push(S_MEMWRITE, 1'b0, rb(), o, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        push(S_MEMWRITE, 1'b1, rb(), o, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      end
      7'b0110011: begin
        push(S_EXECUTER, rb(), rb(), o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0);
        push(S_ALUWB, rb(), rb(), o, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      end
      7'b0010011: begin
        push(S_EXECUTEI, rb(), rb(), o, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0);
        push(S_ALUWB, rb(), rb(), o, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      end
      7'b1100011:
        push(S_BRANCH, rb(), beq, o, !beq, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0);
      7'b1101111: begin
        push(S_JAL, rb(), rb(), o, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0);
        push(S_ALUWB, rb(), rb(), o, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
      end
      default: ;
    endcase
  endtask

  function automatic logic [19:0] dut_vec();
    return {state, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
            ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc, illegal};
  endfunction

  // Monitor: one scoreboard pop per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (checked < driven) begin
      logic [19:0] req;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard: actual=empty queue required=entry at cycle %0d", checked);
      end else begin
        req = exp_q.pop_front();
        $display("cycle %0d op=%b state=%0d vec=%h", checked, op, state, dut_vec());
        check($sformatf("ctrl cycle %0d", checked), dut_vec(), req);
      end
      checked++;
    end
  end

  initial begin
    logic [6:0] rop;
    stim_t      s;
    int         waited;

    // Reset holds FETCH with strobes off even though mem_ready=1.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset state", 20'(state), 20'(S_FETCH));
    check("reset strobes", {15'd0, PCWrite, IRWrite, MemWrite, RegWrite, illegal}, 20'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    gen_instr(7'b0000011, 0, 0, 1'b0);
    gen_instr(7'b0100011, 0, 2, 1'b0);
    gen_instr(7'b1100011, 0, 0, 1'b0);
    gen_instr(7'b1100011, 0, 0, 1'b1);
    gen_instr(7'b1101111, 0, 0, 1'b0);
    gen_instr(7'b1111111, 0, 0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: rop = 7'b0000011;
        1: rop = 7'b0100011;
        2: rop = 7'b0110011;
        3: rop = 7'b0010011;
        4: rop = 7'b1100011;
        5: rop = 7'b1101111;
        6: rop = 7'b1111111;
        default: rop = 7'($urandom());
      endcase
      gen_instr(rop, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0, rb());
    end

    while (stim_q.size() > 0) begin
      @(posedge clk);
      #1;
      s = stim_q.pop_front();
      mem_ready = s.mr;
      EQ = s.eq;
      op = s.op;
      driven++;
    end
    waited = 0;
    while (checked < driven && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (checked < driven) begin
      n_checks++;
      $display("FAIL drain: actual=%0d checked required=%0d", checked, driven);
    end

    // Abort a stalled store with an asynchronous reset between clock edges.
    @(posedge clk); #1; op = 7'b0100011; mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("stalled store", {state, 15'd0, MemWrite}, {4'(S_MEMWRITE), 15'd0, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("async abort", {state, 15'd0, MemWrite}, {4'(S_FETCH), 16'd0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset fetch", {state, 15'd0, IRWrite}, {4'(S_FETCH), 16'd0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
